// File: rtl/rf_scan_reader.sv
// rf_scan_reader: read-side master that walks a contiguous, optionally wrapping
// range of register-file indices and streams each entry out over valid/ready.
//
// Ports:
//   HCLK, HRESETn       clock, asynchronous active-low reset
//   start, first, last  scan request and inclusive index range (sampled in idle)
//   busy, done          scan in progress / one-cycle completion pulse
//   rf_ra, rf_da        register-file read address and combinational read data
//   m_valid, m_ready    output stream handshake
//   m_data, m_index     beat payload and the index it was read from
//   csum, csum_valid    XOR checksum of all transferred beats (optional)
//
// Optional feature: define RF_SCAN_READER_CSUM_EN to add csum/csum_valid.
module rf_scan_reader #(
  parameter int unsigned AW = 6,
  parameter int unsigned DW = 64
) (
  input  logic          HCLK,
  input  logic          HRESETn,
  input  logic          start,
  input  logic [AW-1:0] first,
  input  logic [AW-1:0] last,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] rf_ra,
  input  logic [DW-1:0] rf_da,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_data,
  output logic [AW-1:0] m_index
`ifdef RF_SCAN_READER_CSUM_EN
  ,
  output logic [DW-1:0] csum,
  output logic          csum_valid
`endif
);

  typedef enum logic [1:0] {StIdle, StRead, StDrain} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [AW:0]   rem_q, rem_d;
  logic [AW-1:0] rf_ra_q;
  logic          m_valid_q, m_valid_d;
  logic [DW-1:0] m_data_q, m_data_d;
  logic [AW-1:0] m_index_q, m_index_d;
  logic          done_q, done_d;

  logic          xfer;
  logic          capture;
  logic          start_ok;
  logic [AW-1:0] span;

  assign xfer    = m_valid_q & m_ready;
  // The output register may be refilled when empty or being drained this cycle.
  assign capture = (state_q == StRead) && (!m_valid_q || m_ready);
  // done_q is only ever high in idle; blocking start there defers a new scan by one cycle.
  assign start_ok = (state_q == StIdle) && start && !done_q;
  assign span     = last - first;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    rem_d     = rem_q;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_index_d = m_index_q;
    done_d    = 1'b0;

    if (xfer) m_valid_d = 1'b0;

    if (capture) begin
      m_data_d  = rf_da;
      m_index_d = ptr_q;
      m_valid_d = 1'b1;
      ptr_d     = ptr_q + AW'(1);
      rem_d     = rem_q - (AW+1)'(1);
    end

    unique case (state_q)
      StIdle: begin
        if (start_ok) begin
          ptr_d   = first;
          // Modular span plus one: first==last+1 yields the full 2^AW beats.
          rem_d   = {1'b0, span} + (AW+1)'(1);
          state_d = StRead;
        end
      end
      StRead: begin
        if (capture && rem_q == (AW+1)'(1)) state_d = StDrain;
      end
      StDrain: begin
        if (xfer) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q   <= StIdle;
      ptr_q     <= '0;
      rem_q     <= '0;
      rf_ra_q   <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_index_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      rem_q     <= rem_d;
      // Tracks the next pointer so the file's read data is ready at the capture edge.
      rf_ra_q   <= ptr_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_index_q <= m_index_d;
      done_q    <= done_d;
    end
  end

  assign busy    = (state_q != StIdle);
  assign done    = done_q;
  assign rf_ra   = rf_ra_q;
  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign m_index = m_index_q;

`ifdef RF_SCAN_READER_CSUM_EN
  logic [DW-1:0] csum_q, csum_d;
  logic          csum_valid_q;

  always_comb begin
    csum_d = csum_q;
    if (start_ok)  csum_d = '0;
    else if (xfer) csum_d = csum_q ^ m_data_q;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      csum_q       <= '0;
      csum_valid_q <= 1'b0;
    end else begin
      csum_q       <= csum_d;
      csum_valid_q <= done_d;
    end
  end

  assign csum       = csum_q;
  assign csum_valid = csum_valid_q;
`endif

endmodule

// File: doc/rf_scan_reader.md
Name: rf_scan_reader

Overview:
Read-side master for the 64x64 register file. It walks a contiguous (optionally wrapping) range of register indices, drives the file's read-address port and captures the combinational read data. Each entry is streamed out over a valid/ready interface. Used for debug dump, context save and scan-out of the register file without stalling the core's write port.

Parameters:
AW, 6, register index width; the file has 2^AW entries.
DW, 64, register data width.

Ports:
HCLK  input  1  system clock; all state on rising edge.
HRESETn  input  1  asynchronous active-low reset.
start  input  1  one-cycle request to begin a scan; sampled only in IDLE.
first  input  AW  first index of the scan; sampled with start.
last  input  AW  last index of the scan, inclusive; sampled with start.
busy  output  1  high from the cycle after an accepted start until done.
done  output  1  one-cycle pulse after the final beat is accepted.
rf_ra  output  AW  read address driven to the register file.
rf_da  input  DW  combinational read data returned by the register file for rf_ra.
m_valid  output  1  stream beat valid.
m_ready  input  1  stream sink ready.
m_data  output  DW  beat data.
m_index  output  AW  register index the beat was read from.

Behaviour:
- Clock and reset: one clock, HCLK; reset is asynchronous and active-low, HRESETn.
- Reset values: busy=0, done=0, rf_ra=0, m_valid=0, m_data=0, m_index=0. FSM goes to IDLE.
- Reset mid-scan: aborts immediately; any pending beat is discarded; no done pulse.
- FSM states: IDLE, READ, DRAIN.
- IDLE:
  - On start=1, latch ptr=first and remaining=((last-first) mod 2^AW)+1, using AW+1-bit arithmetic.
  - Go to READ; busy=1 next cycle.
- Scan range and wrap:
  - first==last gives 1 beat.
  - last<first wraps modulo 2^AW, e.g. first=62, last=1 gives indices 62,63,0,1.
  - A full wrap is first=last+1 mod 2^AW, giving 64 beats.
- rf_ra is a registered copy of ptr; it is held stable while no capture occurs.
- Capture condition: state==READ and (m_valid==0 or m_ready==1).
  - On capture: m_data<=rf_da, m_index<=ptr, m_valid<=1, ptr<=ptr+1 (wraps), remaining<=remaining-1.
  - When remaining reaches 1 at a capture, go to DRAIN.
- Throughput: one beat per cycle with m_ready held high. First beat is valid 2 cycles after start, i.e. 1 cycle after entering READ.
- Stream handshake:
  - A beat transfers when m_valid&m_ready.
  - m_data and m_index stay stable while m_valid&~m_ready.
  - m_valid deasserts after a transfer with no new capture.
- DRAIN: waits for the final beat to transfer, then returns to IDLE. done=1 for exactly one cycle and busy=0 in that same cycle.
- start while busy: ignored, with no effect on the in-flight scan.
- start in the same cycle as done: ignored; a new start is accepted from the following cycle.
- Index 0 reads whatever the file returns (zero by file convention); no special casing here.
- Concurrent writes to the file are not blocked. A beat carries the value present on rf_da in its capture cycle.

Optional Feature:
- Macro: RF_SCAN_READER_CSUM_EN.
- When defined, adds outputs csum[DW-1:0] and csum_valid.
  - csum clears to 0 on an accepted start.
  - It is XOR-accumulated with m_data on each transfer.
  - csum_valid pulses together with done.
  - Both outputs reset to 0.
- When undefined, these ports and their logic do not exist; all other behaviour is identical.

Test Plan:
- Reset, then first=3, last=5, start pulse, m_ready=1, RF[i]=i*0x0101 -> beats (3,0x0303),(4,0x0404),(5,0x0505) on consecutive cycles. done pulses one cycle after the last beat; busy drops with done.
- first=62, last=1 -> m_index sequence 62,63,0,1. Beat at index 0 carries 0.
- Full scan first=0, last=63 with m_ready toggling 1,0,1,0 -> exactly 64 beats. m_data and m_index are held during every stall, and no index is skipped or duplicated.
- start re-pulsed mid-scan with first=10 -> ignored; the original sequence completes unchanged.
- HRESETn asserted after 5 beats of a 20-beat scan -> m_valid and busy go to 0 immediately and no done pulse appears. A new scan afterwards starts from its own first.
- With RF_SCAN_READER_CSUM_EN defined, scan indices 1..3 holding 0xF0, 0x0F, 0xFF -> csum=0x00 with csum_valid coincident with done.
